// File: rtl/pll_lock_ctrl.sv
// PLL reset sequencer: pulses pll_rst, waits for a stable synchronised lock,
// then releases sys_rst; retries on timeout and parks in FAIL when exhausted.
module pll_lock_ctrl #(
   parameter int unsigned RST_PULSE_CYC    = 16,
   parameter int unsigned LOCK_TIMEOUT_CYC = 50000,
   parameter int unsigned LOCK_STABLE_CYC  = 1024,
   parameter int unsigned MAX_RETRIES      = 3
) (
   input  logic       refclk,
   input  logic       rst,
   input  logic       locked,
   input  logic       relock_req,
   output logic       pll_rst,
   output logic       sys_rst,
   output logic       lock_fail,
   output logic [3:0] retry_cnt,
   output logic [2:0] dbg_state_o
);

   // dbg_state_o encoding: RESET_PLL=0 WAIT_LOCK=1 STABILIZE=2 RUN=3 FAIL=4
   typedef enum logic [2:0] {
      S_RESET_PLL = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_STABILIZE = 3'd2,
      S_RUN       = 3'd3,
      S_FAIL      = 3'd4
   } state_e;

   localparam int unsigned RW = $clog2(RST_PULSE_CYC + 1);
   localparam int unsigned TW = $clog2(LOCK_TIMEOUT_CYC + 1);
   localparam int unsigned SW = $clog2(LOCK_STABLE_CYC + 1);

   localparam logic [RW-1:0] RST_LAST  = RW'(RST_PULSE_CYC - 1);
   localparam logic [TW-1:0] TO_LAST   = TW'(LOCK_TIMEOUT_CYC - 1);
   localparam logic [SW-1:0] STAB_DONE = SW'(LOCK_STABLE_CYC);
   localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRIES);

   state_e        state_q, state_d;
   logic [1:0]    sync_q;
   logic          locked_s;
   logic [RW-1:0] rst_cnt_q, rst_cnt_d;
   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic [SW-1:0] stab_cnt_q, stab_cnt_d;
   logic [3:0]    retry_q, retry_d;
   logic          timeout;

   assign locked_s = sync_q[1];
   assign timeout  = (to_cnt_q == TO_LAST);

   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         sync_q     <= '0;
         state_q    <= S_RESET_PLL;
         rst_cnt_q  <= '0;
         to_cnt_q   <= '0;
         stab_cnt_q <= '0;
         retry_q    <= '0;
      end else begin
         sync_q     <= {sync_q[0], locked};
         state_q    <= state_d;
         rst_cnt_q  <= rst_cnt_d;
         to_cnt_q   <= to_cnt_d;
         stab_cnt_q <= stab_cnt_d;
         retry_q    <= retry_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      retry_d    = retry_q;
      rst_cnt_d  = '0;
      to_cnt_d   = to_cnt_q;
      stab_cnt_d = '0;
      case (state_q)
         S_RESET_PLL: begin
            to_cnt_d = '0;
            if (rst_cnt_q == RST_LAST) begin
               state_d = S_WAIT_LOCK;
            end else begin
               rst_cnt_d = (rst_cnt_q == '1) ? rst_cnt_q : rst_cnt_q + RW'(1);
            end
         end
         S_WAIT_LOCK, S_STABILIZE: begin
            // One timeout window covers both waiting and stabilising.
            to_cnt_d = (to_cnt_q == '1) ? to_cnt_q : to_cnt_q + TW'(1);
            if (timeout) begin
               if (retry_q < RETRY_MAX) begin
                  retry_d = retry_q + 4'd1;
                  state_d = S_RESET_PLL;
               end else begin
                  state_d = S_FAIL;
               end
            end else if (state_q == S_WAIT_LOCK) begin
               if (locked_s) state_d = S_STABILIZE;
            end else if (!locked_s) begin
               state_d = S_WAIT_LOCK;
            end else if (stab_cnt_q == STAB_DONE) begin
               state_d = S_RUN;
            end else begin
               stab_cnt_d = (stab_cnt_q == '1) ? stab_cnt_q : stab_cnt_q + SW'(1);
            end
         end
         S_RUN: begin
            if (!locked_s || relock_req) begin
               retry_d = '0;
               state_d = S_RESET_PLL;
            end
         end
         S_FAIL: begin
            if (relock_req) begin
               retry_d = '0;
               state_d = S_RESET_PLL;
            end
         end
         default: state_d = S_RESET_PLL;
      endcase
   end

   assign pll_rst     = (state_q == S_RESET_PLL);
   assign sys_rst     = (state_q != S_RUN);
   assign lock_fail   = (state_q == S_FAIL);
   assign retry_cnt   = retry_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Bench for pll_lock_ctrl: directed scenarios with literal expectations plus
// randomized lock/relock/reset traffic checked every cycle against a timeline model.
module tb_pll_lock_ctrl;

   localparam int RP = 4;
   localparam int TO = 20;
   localparam int ST = 8;
   localparam int MR = 2;

   logic       refclk = 1'b0;
   logic       rst;
   logic       locked;
   logic       relock_req;
   logic       pll_rst;
   logic       sys_rst;
   logic       lock_fail;
   logic [3:0] retry_cnt;
   logic [2:0] dbg_state;

   int n_checks = 0;
   int n_fail   = 0;
   bit cmp_en   = 1'b0;
   int k, w, len;
   logic cur;
   int runs[$];
   bit saw_low;

   always #5 refclk = ~refclk;

   pll_lock_ctrl #(
      .RST_PULSE_CYC   (RP),
      .LOCK_TIMEOUT_CYC(TO),
      .LOCK_STABLE_CYC (ST),
      .MAX_RETRIES     (MR)
   ) dut (
      .refclk     (refclk),
      .rst        (rst),
      .locked     (locked),
      .relock_req (relock_req),
      .pll_rst    (pll_rst),
      .sys_rst    (sys_rst),
      .lock_fail  (lock_fail),
      .retry_cnt  (retry_cnt),
      .dbg_state_o(dbg_state)
   );

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge refclk);
         #1;
      end
   endtask

   // Timeline model: phases with the edge numbers at which they began.
   typedef enum int {M_RST, M_WAIT, M_STAB, M_RUN, M_FAIL} mphase_e;
   mphase_e m_phase;
   int      m_n, m_t_pulse, m_t_wait, m_t_stab, m_retries;
   bit      m_lh0, m_lh1;

   task automatic model_reset();
      m_phase   = M_RST;
      m_n       = 0;
      m_t_pulse = 0;
      m_t_wait  = 0;
      m_t_stab  = 0;
      m_retries = 0;
      m_lh0     = 1'b0;
      m_lh1     = 1'b0;
   endtask

   task automatic model_pulse();
      m_phase   = M_RST;
      m_t_pulse = m_n;
   endtask

   task automatic model_step();
      bit ls;
      ls    = m_lh1;
      m_lh1 = m_lh0;
      m_lh0 = locked;
      m_n++;
      case (m_phase)
         M_RST: begin
            if (m_n - m_t_pulse == RP) begin
               m_phase  = M_WAIT;
               m_t_wait = m_n;
            end
         end
         M_WAIT, M_STAB: begin
            if (m_n - m_t_wait == TO) begin
               if (m_retries < MR) begin
                  m_retries++;
                  model_pulse();
               end else begin
                  m_phase = M_FAIL;
               end
            end else if (m_phase == M_WAIT) begin
               if (ls) begin
                  m_phase  = M_STAB;
                  m_t_stab = m_n;
               end
            end else if (!ls) begin
               m_phase = M_WAIT;
            end else if (m_n - m_t_stab == ST + 1) begin
               m_phase = M_RUN;
            end
         end
         M_RUN: begin
            if (!ls || relock_req) begin
               m_retries = 0;
               model_pulse();
            end
         end
         M_FAIL: begin
            if (relock_req) begin
               m_retries = 0;
               model_pulse();
            end
         end
         default: model_reset();
      endcase
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge refclk or posedge rst);
         if (rst) model_reset();
         else     model_step();
      end
   end

   initial begin
      forever begin
         @(negedge refclk);
         if (cmp_en) begin
            check("cyc_pll_rst",   int'(pll_rst),   int'(m_phase == M_RST));
            check("cyc_sys_rst",   int'(sys_rst),   int'(m_phase != M_RUN));
            check("cyc_lock_fail", int'(lock_fail), int'(m_phase == M_FAIL));
            check("cyc_retry_cnt", int'(retry_cnt), m_retries);
         end
      end
   end

   initial begin
      rst        = 1'b1;
      locked     = 1'b0;
      relock_req = 1'b0;
      cmp_en     = 1'b1;
      tick(3);
      check("reset_pll_rst",   int'(pll_rst),   1);
      check("reset_sys_rst",   int'(sys_rst),   1);
      check("reset_lock_fail", int'(lock_fail), 0);
      check("reset_retry_cnt", int'(retry_cnt), 0);
      check("reset_dbg_state", int'(dbg_state), 0);
      rst = 1'b0;

      // Clean lock
      w = 0;
      do begin tick(1); w++; end while (pll_rst && w < 50);
      check("clean_pulse_width", w, RP);
      tick(2);
      locked = 1'b1;
      tick(1);
      k = 0;
      do begin tick(1); k++; end while (sys_rst && k < 100);
      check("clean_lock_latency", k, 11);
      check("clean_lock_fail", int'(lock_fail), 0);
      check("clean_retry_cnt", int'(retry_cnt), 0);

      // Loss of lock in RUN
      tick(4);
      locked = 1'b0;
      k = 0;
      do begin tick(1); k++; end while (!pll_rst && k < 20);
      check("loss_to_pll_rst", k, 3);
      check("loss_sys_rst", int'(sys_rst), 1);
      w = 0;
      do begin tick(1); w++; end while (pll_rst && w < 50);
      check("loss_pulse_width", w, RP);
      check("loss_retry_cnt", int'(retry_cnt), 0);

      // Never locks, with a relock_req during WAIT_LOCK that must be ignored
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      cur = pll_rst;
      len = 1;
      for (int i = 0; i < 150; i++) begin
         tick(1);
         if (i == 10) relock_req = 1'b1;
         if (i == 11) relock_req = 1'b0;
         if (pll_rst == cur) begin
            len++;
         end else begin
            runs.push_back(len);
            cur = pll_rst;
            len = 1;
         end
      end
      check("nolock_run_count", runs.size(), 5);
      for (int j = 0; j < runs.size() && j < 5; j++)
         check("nolock_run_len", runs[j], (j % 2 == 0) ? RP : TO);
      check("nolock_lock_fail", int'(lock_fail), 1);
      check("nolock_retry_cnt", int'(retry_cnt), MR);
      check("nolock_pll_rst",   int'(pll_rst),   0);
      check("nolock_sys_rst",   int'(sys_rst),   1);
      check("nolock_dbg_state", int'(dbg_state), 4);

      // Recovery from FAIL
      relock_req = 1'b1;
      tick(1);
      relock_req = 1'b0;
      check("recover_lock_fail", int'(lock_fail), 0);
      check("recover_retry_cnt", int'(retry_cnt), 0);
      check("recover_pll_rst",   int'(pll_rst),   1);
      w = 0;
      do begin tick(1); w++; end while (pll_rst && w < 50);
      check("recover_pulse_width", w, RP);

      // Glitch in STABILIZE; relock then completes on the timeout cycle, timeout wins
      locked = 1'b1;
      tick(5);
      locked = 1'b0;
      tick(3);
      locked = 1'b1;
      k = 0;
      saw_low = 1'b0;
      do begin
         tick(1);
         k++;
         if (!sys_rst) saw_low = 1'b1;
      end while (!pll_rst && k < 40);
      check("glitch_retry_latency", k, 12);
      check("glitch_sys_rst_low", int'(saw_low), 0);
      check("glitch_retry_cnt", int'(retry_cnt), 1);

      // Asynchronous reset mid-STABILIZE
      w = 0;
      do begin tick(1); w++; end while (pll_rst && w < 50);
      tick(4);
      check("pre_async_retry", int'(retry_cnt), 1);
      #3;
      rst = 1'b1;
      #1;
      check("async_pll_rst",   int'(pll_rst),   1);
      check("async_sys_rst",   int'(sys_rst),   1);
      check("async_retry_cnt", int'(retry_cnt), 0);
      check("async_lock_fail", int'(lock_fail), 0);
      tick(1);
      rst = 1'b0;

      // Randomized traffic
      for (int seg = 0; seg < 60; seg++) begin
         int mode;
         int seg_len;
         mode    = $urandom_range(0, 3);
         seg_len = $urandom_range(10, 150);
         for (int i = 0; i < seg_len; i++) begin
            tick(1);
            if (rst) rst = 1'b0;
            case (mode)
               0:       locked = 1'b0;
               1:       locked = 1'b1;
               2:       locked = 1'($urandom_range(0, 1));
               default: locked = ($urandom_range(0, 40) != 0);
            endcase
            relock_req = ($urandom_range(0, 25) == 0);
            if ($urandom_range(0, 700) == 0) begin
               #3;
               rst = 1'b1;
            end
         end
      end
      tick(1);
      rst        = 1'b0;
      relock_req = 1'b0;
      tick(2);
      cmp_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
